// File: rtl/clkg_ctrl.sv
// Clock-enable scheduler: NCH independently divided clocks from the system clock.
// Divisor/enable writes are staged and only take effect at a period boundary.
module clkg_ctrl #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8,
    localparam int unsigned CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    input  logic           cfg_en,
    output logic [NCH-1:0] clko,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] active,
    output logic [NCH-1:0] pend
);

    typedef enum logic {StOff, StRun} state_e;

    state_e        state_q [NCH];
    state_e        state_d [NCH];
    logic [DW-1:0] cnt_q   [NCH];
    logic [DW-1:0] cnt_d   [NCH];
    logic [DW-1:0] div_q   [NCH];
    logic [DW-1:0] div_d   [NCH];
    logic [DW-1:0] sdiv_q  [NCH];
    logic [DW-1:0] sdiv_d  [NCH];
    logic [NCH-1:0] sen_q, sen_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] clko_q, clko_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic           wr;

    assign cfg_ready = !pend_q[cfg_ch];
    assign wr        = cfg_valid && cfg_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sdiv_d  = sdiv_q;
        sen_d   = sen_q;
        pend_d  = pend_q;
        clko_d  = clko_q;
        tick_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            unique case (state_q[i])
                StOff: begin
                    cnt_d[i]  = '0;
                    clko_d[i] = 1'b0;
                    if (pend_q[i]) begin
                        div_d[i]  = sdiv_q[i];
                        pend_d[i] = 1'b0;
                        if (sen_q[i]) state_d[i] = StRun;
                    end
                end
                StRun: begin
                    if (cnt_q[i] != div_q[i]) begin
                        cnt_d[i] = cnt_q[i] + DW'(1);
                    end else begin
                        cnt_d[i] = '0;
                        if (!clko_q[i]) begin
                            clko_d[i] = 1'b1;
                            tick_d[i] = 1'b1;
                        end else begin
                            // End of high phase: the only point a staged write may land.
                            clko_d[i] = 1'b0;
                            if (pend_q[i]) begin
                                div_d[i]   = sdiv_q[i];
                                pend_d[i]  = 1'b0;
                                state_d[i] = sen_q[i] ? StRun : StOff;
                            end
                        end
                    end
                end
                default: state_d[i] = StOff;
            endcase
            // Accepted writes only target non-pending channels, so never collide with an apply.
            if (wr && (cfg_ch == CW'(i))) begin
                sdiv_d[i] = cfg_div;
                sen_d[i]  = cfg_en;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= StOff;
                cnt_q[i]   <= '0;
                div_q[i]   <= '0;
                sdiv_q[i]  <= '0;
            end
            sen_q  <= '0;
            pend_q <= '0;
            clko_q <= '0;
            tick_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sdiv_q  <= sdiv_d;
            sen_q   <= sen_d;
            pend_q  <= pend_d;
            clko_q  <= clko_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) active[i] = (state_q[i] == StRun);
    end

    assign clko = clko_q;
    assign tick = tick_q;
    assign pend = pend_q;

endmodule

// File: tb/tb_clkg_ctrl.sv
// Bench for clkg_ctrl: directed scenarios plus random writes against a
// period-position reference model.
module tb_clkg_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_en = 1'b0;
    logic [3:0] clko, tick, active, pend;

    int checks = 0;
    int errors = 0;

    // Model: each running channel sits at position pos in a 2*(D+1) period;
    // positions 0..D are low, D+1..2D+1 high, rise at D+1.
    int m_div [4];
    int m_sd  [4];
    int m_pos [4];
    bit m_run [4];
    bit m_sen [4];
    bit m_pend[4];

    clkg_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .clko      (clko),
        .tick      (tick),
        .active    (active),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_vec(input int kind);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) begin
            case (kind)
                0: v[i] = m_run[i] && (m_pos[i] > m_div[i]);
                1: v[i] = m_run[i] && (m_pos[i] == m_div[i] + 1);
                2: v[i] = m_run[i];
                default: v[i] = m_pend[i];
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_edge(input bit acc, input int ch, input int d, input bit e);
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_div[i] = 0; m_sd[i] = 0; m_pos[i] = 0;
                m_run[i] = 0; m_sen[i] = 0; m_pend[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (!m_run[i]) begin
                if (m_pend[i]) begin
                    m_div[i] = m_sd[i];
                    m_pend[i] = 0;
                    m_run[i] = m_sen[i];
                    m_pos[i] = 0;
                end
            end else if (m_pos[i] == 2 * m_div[i] + 1) begin
                m_pos[i] = 0;
                if (m_pend[i]) begin
                    m_div[i] = m_sd[i];
                    m_pend[i] = 0;
                    m_run[i] = m_sen[i];
                end
            end else begin
                m_pos[i]++;
            end
        end
        if (acc) begin
            m_sd[ch] = d;
            m_sen[ch] = e;
            m_pend[ch] = 1;
        end
    endtask

    // One clock: drive inputs, check ready, clock, advance model, check outputs.
    task automatic step(input bit v, input int ch, input int d, input bit e, output bit acc);
        cfg_valid = v;
        cfg_ch = 2'(ch);
        cfg_div = 8'(d);
        cfg_en = e;
        #1;
        checks++;
        assert (cfg_ready === !m_pend[ch]) else begin
            errors++;
            $error("FAIL cfg_ready observed=%b expected=%b at %0t", cfg_ready, !m_pend[ch], $time);
        end
        acc = v && !m_pend[ch] && !reset;
        @(posedge clk);
        model_edge(acc, ch, d, e);
        #1;
        chk("clko", clko, exp_vec(0));
        chk("tick", tick, exp_vec(1));
        chk("active", active, exp_vec(2));
        chk("pend", pend, exp_vec(3));
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, a);
    endtask

    // Hold a write until accepted, bounded.
    task automatic write(input int ch, input int d, input bit e);
        bit a;
        a = 0;
        for (int k = 0; k < 2000 && !a; k++) step(1, ch, d, e, a);
        if (!a) begin
            errors++;
            $error("FAIL write_timeout ch=%0d observed=not_accepted expected=accepted", ch);
        end
    endtask

    task automatic wait_for(input int ch, input int pos, input bit hi);
        bit hit;
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            if (m_run[ch] && (hi ? (m_pos[ch] > m_div[ch]) : (m_pos[ch] == pos))) hit = 1;
            else idle(1);
        end
        checks++;
        if (!hit) begin
            errors++;
            $error("FAIL wait_timeout ch=%0d observed=unreached expected=reached", ch);
        end
    endtask

    initial begin
        bit a;
        int rch, rd;
        for (int i = 0; i < 4; i++) begin
            m_div[i] = 0; m_sd[i] = 0; m_pos[i] = 0;
            m_run[i] = 0; m_sen[i] = 0; m_pend[i] = 0;
        end
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);

        write(0, 0, 1);           // clk/2
        idle(8);
        write(1, 3, 1);
        idle(20);
        wait_for(1, 0, 1);        // mid high phase
        write(1, 1, 1);
        idle(16);
        wait_for(1, 1, 0);        // cnt=1 of low phase
        write(1, 9, 0);
        idle(20);

        write(2, 5, 1);
        step(1, 2, 2, 1, a);      // must stall behind the first
        step(1, 3, 4, 1, a);      // other channel accepted at once
        write(2, 2, 1);
        idle(30);
        write(2, 2, 1);           // identical rewrite, no phase change
        idle(12);

        write(3, 255, 1);         // widest divisor: half-period 256
        idle(560);

        for (int k = 0; k < 1500; k++) begin
            rch = int'($urandom_range(3, 0));
            rd = ($urandom_range(15, 0) == 0) ? 255 : int'($urandom_range(4, 0));
            step($urandom_range(3, 0) == 0, rch, rd, $urandom_range(4, 0) != 0, a);
        end

        for (int i = 0; i < 4; i++) write(i, 1, 1);
        idle(6);
        for (int i = 0; i < 4; i++) write(i, 7, 1);
        reset = 1'b1;
        step(1, 0, 3, 1, a);      // ignored while reset is high
        reset = 1'b0;
        idle(10);
        write(0, 1, 1);
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkg_ctrl.md
# clkg_ctrl

Runtime-configurable clock-enable scheduler serving NCH independent divided-clock channels from the single system clock. Replaces fixed-ratio dividers: software/control logic writes a divisor and enable per channel through a valid/ready config port. Updates are staged and applied only at a period boundary, so the divided outputs never glitch or emit a runt phase. Sits between the system clock domain and the slow peripheral blocks that consume `clko`/`tick`.

## Interface
- `NCH`, 4, number of channels (power of two, ≥2)
- `DW`, 8, divisor width
- `CW`, log2(NCH), channel-select width (derived, not overridden)

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  config write can be accepted this cycle
- `cfg_ch`  in  CW  target channel
- `cfg_div`  in  DW  divisor D; half-period = D+1 clk cycles
- `cfg_en`  in  1  1 = run channel, 0 = stop channel
- `clko`  out  NCH  divided clock per channel, registered
- `tick`  out  NCH  one-cycle pulse coincident with each clko rising transition
- `active`  out  NCH  channel state is RUN
- `pend`  out  NCH  channel holds a staged, not yet applied, write

## Operation
- Per channel: state {OFF, RUN}, counter cnt[DW-1:0], live div, staged div/en, pend flag.
- `cfg_ready` = !pend[cfg_ch] (combinational from registered pend). Write accepted when cfg_valid && cfg_ready; stores cfg_div/cfg_en into channel's staging, sets pend.
- OFF channel with pend: on the next edge loads div, clears pend; if staged en=1 → RUN, cnt=0, clko=0; if en=0 → stays OFF.
- RUN, cnt<div: cnt+1.
- RUN, cnt==div, clko=0: clko←1, tick←1, cnt←0.
- RUN, cnt==div, clko=1 (period boundary): clko←0, cnt←0; if pend: load div, clear pend, state←RUN if en=1 else OFF.
- tick is 0 in every other cycle; OFF channels: clko=0, tick=0, cnt held at 0.
- Channels are fully independent; writes to one never disturb another.
- D=0 gives clk/2; D=2^DW−1 gives half-period 2^DW.

## Timing
- Reset values: clko=0, tick=0, active=0, pend=0, cfg_ready=1, all cnt=0, all div=0, all states OFF.
- Write latency to OFF channel: accepted at edge N → active=1 at edge N+1 → first clko rise/tick at edge N+1+(D+1).
- Write to RUN channel: applied at the first period boundary after acceptance; current period always completes at old divisor.
- Second write to a pending channel: cfg_ready=0, requester stalls; cfg_ready returns 1 in the cycle after the applying edge.
- Disable (en=0) takes effect at boundary, so clko ends low after a full high phase; no truncated pulse.
- Rewrite with identical div/en: applied at boundary with no phase change.
- reset asserted mid-operation: all outputs to reset values at that edge; staged writes discarded; cfg_valid ignored while reset is high.
- No combinational path from cfg_* to clko/tick/active/pend.

## Test plan
- Reset, write ch0 D=0 en=1 → active[0]=1 next cycle; clko[0] toggles every cycle (period 2); tick[0] every 2nd cycle; other channels stay 0.
- Write ch1 D=3 en=1 → clko[1] 4 cycles low, 4 high, repeating; tick[1] once per 8 cycles, coincident with rise.
- ch1 running D=3, write D=1 mid-high-phase → pend[1]=1, cfg_ready low for ch1; current phase finishes at 4 cycles; next period 2 low/2 high; pend clears at boundary.
- ch1 running, write en=0 at cnt=1 of low phase → low and high phases complete, clko[1]=0 and active[1]=0 after boundary; no further ticks.
- Back-to-back writes ch2 D=5 then ch2 D=2 → second held (cfg_ready=0) until first applies; ch3 write in same window accepted immediately.
- Assert reset for 1 cycle while all channels run with pend set → all outputs zero, pend cleared, cfg_ready=1; channels stay OFF until rewritten.
